split_delayer_lfsr: RTL and testbench

SPLIT_DELAYER_LFSR -- requirements
Module: split_delayer_lfsr

---
 rtl/split_delayer_lfsr.sv | 200 ++++++++++++++++++++
 tb/tb_split_delayer_lfsr.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/split_delayer_lfsr.sv
// Split-transaction delayer: LFSR-gated request pass-through plus a response FIFO with randomised return.
// Define SPLIT_DELAYER_STATS_EN to add the saturating stall statistics ports.
module split_delayer_lfsr #(
   parameter int          DATA_WIDTH    = 32,
   parameter int          ADDR_WIDTH    = 32,
   parameter int          REQ_PASS      = 64,
   parameter int          RESP_PASS     = 64,
   parameter int          MAX_STALL     = 16,
   parameter int          RESP_FIFO_POW = 4,
   parameter logic [15:0] SEED          = 16'hACE1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      host_req,
   input  logic                      host_we,
   input  logic [ADDR_WIDTH-1:0]     host_addr,
   input  logic [DATA_WIDTH-1:0]     host_wdata,
   input  logic [DATA_WIDTH/8-1:0]   host_be,
   output logic                      host_ack,
   output logic                      host_resp,
   output logic [DATA_WIDTH-1:0]     host_rdata,
   output logic                      target_req,
   output logic                      target_we,
   output logic [ADDR_WIDTH-1:0]     target_addr,
   output logic [DATA_WIDTH-1:0]     target_wdata,
   output logic [DATA_WIDTH/8-1:0]   target_be,
   input  logic                      target_ack,
   input  logic                      target_resp,
   input  logic [DATA_WIDTH-1:0]     target_rdata,
   output logic                      err_o
`ifdef SPLIT_DELAYER_STATS_EN
   ,
   output logic [31:0]               req_stall_cnt_o,
   output logic [31:0]               resp_stall_cnt_o
`endif
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int DEPTH = 1 << RESP_FIFO_POW;
   localparam int CW    = RESP_FIFO_POW + 1;
   localparam int SW    = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL);

   localparam logic [SW-1:0]            STALL_LIM  = SW'(MAX_STALL - 1);
   localparam logic [SW-1:0]            STALL_ONE  = SW'(1);
   localparam logic [8:0]               REQ_THR    = 9'(REQ_PASS);
   localparam logic [8:0]               RESP_THR   = 9'(RESP_PASS);
   localparam logic [CW-1:0]            CNT_ONE    = CW'(1);
   localparam logic [CW-1:0]            CNT_ZERO   = CW'(0);
   localparam logic [CW-1:0]            CNT_FULL   = CW'(DEPTH);
   localparam logic [CW:0]              CREDIT_LIM = (CW + 1)'(DEPTH);
   localparam logic [RESP_FIFO_POW-1:0] PTR_ONE    = RESP_FIFO_POW'(1);

   logic [15:0]              lfsr_r;
   logic [SW-1:0]            req_stall_r;
   logic [SW-1:0]            resp_stall_r;
   logic [CW-1:0]            outstanding_r;
   logic [CW-1:0]            count_r;
   logic [RESP_FIFO_POW-1:0] wr_ptr_r;
   logic [RESP_FIFO_POW-1:0] rd_ptr_r;
   logic [DATA_WIDTH-1:0]    mem_r [DEPTH];
   logic                     err_r;

   logic [CW:0] credit_sum_s;
   logic        credit_ok_s;
   logic        req_pass_s;
   logic        gate_s;
   logic        accept_rd_s;
   logic        full_s;
   logic        empty_s;
   logic        resp_pass_s;
   logic        pop_s;
   logic        push_s;
   logic        overflow_s;

   // Galois form, taps 16,14,13,11 -> feedback mask 16'hB400 on a right shift
   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      logic [15:0] shifted;
      shifted = {1'b0, cur[15:1]};
      return cur[0] ? (shifted ^ 16'hB400) : shifted;
   endfunction

   // Request gate; outstanding reads and queued responses share the FIFO credit
   always_comb begin
      credit_sum_s = {1'b0, outstanding_r} + {1'b0, count_r};
      credit_ok_s  = (credit_sum_s < CREDIT_LIM);
      req_pass_s   = ({1'b0, lfsr_r[7:0]} < REQ_THR) || (req_stall_r == STALL_LIM);
      gate_s       = rst_i && req_pass_s && (host_we || credit_ok_s);
   end

   // Request path is combinational; rst_i in gate_s keeps everything quiet during reset
   always_comb begin
      if (gate_s) begin
         target_req   = host_req;
         target_we    = host_we;
         target_addr  = host_addr;
         target_wdata = host_wdata;
         target_be    = host_be;
         host_ack     = host_req && target_ack;
      end else begin
         target_req   = 1'b0;
         target_we    = 1'b0;
         target_addr  = {ADDR_WIDTH{1'b0}};
         target_wdata = {DATA_WIDTH{1'b0}};
         target_be    = {BE_W{1'b0}};
         host_ack     = 1'b0;
      end
   end

   assign accept_rd_s = host_ack && !host_we;
   assign full_s      = (count_r == CNT_FULL);
   assign empty_s     = (count_r == CNT_ZERO);
   assign resp_pass_s = ({1'b0, lfsr_r[15:8]} < RESP_THR) || (resp_stall_r == STALL_LIM) || full_s;
   assign pop_s       = rst_i && !empty_s && resp_pass_s;
   assign push_s      = target_resp && (!full_s || pop_s);
   assign overflow_s  = target_resp && full_s && !pop_s;

   // Response presentation: head of FIFO only in the pop cycle
   always_comb begin
      if (pop_s) begin
         host_resp  = 1'b1;
         host_rdata = mem_r[rd_ptr_r];
      end else begin
         host_resp  = 1'b0;
         host_rdata = {DATA_WIDTH{1'b0}};
      end
   end

   assign err_o = err_r;

   // LFSR free-runs every cycle
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) lfsr_r <= SEED;
      else        lfsr_r <= lfsr_next(lfsr_r);
   end

   // Stall counters saturate at the forced-pass value so a credit-blocked read stays forced
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         req_stall_r  <= {SW{1'b0}};
         resp_stall_r <= {SW{1'b0}};
      end else begin
         if (!host_req || host_ack)                    req_stall_r <= {SW{1'b0}};
         else if (!gate_s && req_stall_r != STALL_LIM) req_stall_r <= req_stall_r + STALL_ONE;
         else                                          req_stall_r <= req_stall_r;
         if (empty_s || pop_s)                  resp_stall_r <= {SW{1'b0}};
         else if (resp_stall_r != STALL_LIM)    resp_stall_r <= resp_stall_r + STALL_ONE;
         else                                   resp_stall_r <= resp_stall_r;
      end
   end

   // Read credit, FIFO pointers/occupancy and sticky overflow flag
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         outstanding_r <= CNT_ZERO;
         count_r       <= CNT_ZERO;
         wr_ptr_r      <= {RESP_FIFO_POW{1'b0}};
         rd_ptr_r      <= {RESP_FIFO_POW{1'b0}};
         err_r         <= 1'b0;
      end else begin
         case ({accept_rd_s, pop_s})
            2'b10:   outstanding_r <= outstanding_r + CNT_ONE;
            2'b01:   outstanding_r <= outstanding_r - CNT_ONE;
            default: outstanding_r <= outstanding_r;
         endcase
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         if (overflow_s) err_r <= 1'b1;
      end
   end

   // Storage needs no reset: pointers define what is valid
   always_ff @(posedge clk_i) begin
      if (push_s) mem_r[wr_ptr_r] <= target_rdata;
   end

`ifdef SPLIT_DELAYER_STATS_EN
   logic [31:0] req_stat_r;
   logic [31:0] resp_stat_r;

   // Saturating counts of waiting cycles with the gate closed
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         req_stat_r  <= 32'd0;
         resp_stat_r <= 32'd0;
      end else begin
         if (host_req && !gate_s && req_stat_r != 32'hFFFF_FFFF) req_stat_r <= req_stat_r + 32'd1;
         if (!empty_s && !pop_s && resp_stat_r != 32'hFFFF_FFFF) resp_stat_r <= resp_stat_r + 32'd1;
      end
   end

   assign req_stall_cnt_o  = req_stat_r;
   assign resp_stall_cnt_o = resp_stat_r;
`endif

endmodule

// File: tb/tb_split_delayer_lfsr.sv
// Bench for split_delayer_lfsr: one always-pass instance and one always-stall instance,
// responses checked by scoreboard monitors against expected-data queues.
module tb_split_delayer_lfsr;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_a [$];
   logic [31:0] exp_b [$];
   logic [15:0] lfsr_exp [7] = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h0E27, 16'hB313};

   logic a_host_req, a_host_we, a_host_ack, a_host_resp, a_target_req, a_target_we;
   logic a_target_ack, a_target_resp, a_err;
   logic [31:0] a_host_addr, a_host_wdata, a_host_rdata, a_target_addr, a_target_wdata, a_target_rdata;
   logic [3:0]  a_host_be, a_target_be;
   logic b_host_req, b_host_we, b_host_ack, b_host_resp, b_target_req, b_target_we;
   logic b_target_ack, b_target_resp, b_err;
   logic [31:0] b_host_addr, b_host_wdata, b_host_rdata, b_target_addr, b_target_wdata, b_target_rdata;
   logic [3:0]  b_host_be, b_target_be;
`ifdef SPLIT_DELAYER_STATS_EN
   logic [31:0] a_req_stat, a_resp_stat, b_req_stat, b_resp_stat;
`endif

   split_delayer_lfsr #(.REQ_PASS(256), .RESP_PASS(256)) dut_a (
      .clk_i(clk), .rst_i(rst_n),
      .host_req(a_host_req), .host_we(a_host_we), .host_addr(a_host_addr),
      .host_wdata(a_host_wdata), .host_be(a_host_be), .host_ack(a_host_ack),
      .host_resp(a_host_resp), .host_rdata(a_host_rdata),
      .target_req(a_target_req), .target_we(a_target_we), .target_addr(a_target_addr),
      .target_wdata(a_target_wdata), .target_be(a_target_be), .target_ack(a_target_ack),
      .target_resp(a_target_resp), .target_rdata(a_target_rdata), .err_o(a_err)
`ifdef SPLIT_DELAYER_STATS_EN
      , .req_stall_cnt_o(a_req_stat), .resp_stall_cnt_o(a_resp_stat)
`endif
   );

   split_delayer_lfsr #(.REQ_PASS(0), .RESP_PASS(0), .MAX_STALL(4), .RESP_FIFO_POW(2)) dut_b (
      .clk_i(clk), .rst_i(rst_n),
      .host_req(b_host_req), .host_we(b_host_we), .host_addr(b_host_addr),
      .host_wdata(b_host_wdata), .host_be(b_host_be), .host_ack(b_host_ack),
      .host_resp(b_host_resp), .host_rdata(b_host_rdata),
      .target_req(b_target_req), .target_we(b_target_we), .target_addr(b_target_addr),
      .target_wdata(b_target_wdata), .target_be(b_target_be), .target_ack(b_target_ack),
      .target_resp(b_target_resp), .target_rdata(b_target_rdata), .err_o(b_err)
`ifdef SPLIT_DELAYER_STATS_EN
      , .req_stall_cnt_o(b_req_stat), .resp_stall_cnt_o(b_resp_stat)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Scoreboard monitors: every presented response must match the head of its queue
   always begin
      @(negedge clk);
      #2;
      if (a_host_resp === 1'b1) begin
         if (exp_a.size() == 0) check("a_resp_unexpected", {31'd0, a_host_resp}, 32'd0);
         else                   check("a_rdata", a_host_rdata, exp_a.pop_front());
      end
      if (b_host_resp === 1'b1) begin
         if (exp_b.size() == 0) check("b_resp_unexpected", {31'd0, b_host_resp}, 32'd0);
         else                   check("b_rdata", b_host_rdata, exp_b.pop_front());
      end else begin
         check("b_rdata_idle", b_host_rdata, 32'd0);
      end
   end

   task automatic drain(input int sel, input string name);
      int n = 0;
      while (((sel == 0) ? exp_a.size() : exp_b.size()) != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      #3;
      check(name, (sel == 0) ? exp_a.size() : exp_b.size(), 32'd0);
   endtask

   // Holds a request on dut_b until acked; returns the 0-based cycle of the ack (-1 on timeout)
   task automatic issue_b(input logic we, input logic [31:0] addr, input logic [31:0] data, output int ack_at);
      ack_at = -1;
      b_host_req = 1'b1; b_host_we = we; b_host_addr = addr; b_host_wdata = data; b_host_be = 4'hF;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (k == 0) check("b_closed_target_req", {31'd0, b_target_req}, 32'd0);
         if (b_host_ack) begin
            ack_at = k;
            check("b_open_addr", b_target_addr, addr);
            check("b_open_wdata", b_target_wdata, data);
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      b_host_req = 1'b0; b_host_we = 1'b0; b_host_addr = 32'd0; b_host_wdata = 32'd0; b_host_be = 4'd0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int at, acks, rc, ac;
      rst_n = 1'b0;
      a_host_req = 1'b1; a_host_we = 1'b1; a_host_addr = 32'hCAFE_0000; a_host_wdata = 32'h1111_2222;
      a_host_be = 4'hF; a_target_ack = 1'b1; a_target_resp = 1'b0; a_target_rdata = 32'd0;
      b_host_req = 1'b0; b_host_we = 1'b0; b_host_addr = 32'd0; b_host_wdata = 32'd0; b_host_be = 4'd0;
      b_target_ack = 1'b1; b_target_resp = 1'b0; b_target_rdata = 32'd0;

      // outputs quiet during reset even with a request pending on the always-pass instance
      repeat (2) @(negedge clk);
      #1;
      check("rst_target_req", {31'd0, a_target_req}, 32'd0);
      check("rst_host_ack", {31'd0, a_host_ack}, 32'd0);
      check("rst_target_addr", a_target_addr, 32'd0);
      check("rst_target_wdata", a_target_wdata, 32'd0);
      check("rst_host_resp", {31'd0, a_host_resp}, 32'd0);
      check("rst_err", {31'd0, b_err}, 32'd0);
      @(negedge clk);
      a_host_req = 1'b0; a_host_we = 1'b0; a_target_ack = 1'b0;
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         if (i != 0) @(negedge clk);
         #1;
         check("lfsr_seq", {16'd0, dut_a.lfsr_r}, {16'd0, lfsr_exp[i]});
      end

      // always-pass write: pass-through and ack mirrors target_ack
      @(negedge clk);
      a_host_req = 1'b1; a_host_we = 1'b1; a_host_addr = 32'h1000_0040;
      a_host_wdata = 32'hDEAD_BEEF; a_host_be = 4'b1010; a_target_ack = 1'b0;
      #1;
      check("a_pass_req", {31'd0, a_target_req}, 32'd1);
      check("a_pass_we", {31'd0, a_target_we}, 32'd1);
      check("a_pass_addr", a_target_addr, 32'h1000_0040);
      check("a_pass_wdata", a_target_wdata, 32'hDEAD_BEEF);
      check("a_pass_be", {28'd0, a_target_be}, 32'h0000_000A);
      check("a_ack_wait", {31'd0, a_host_ack}, 32'd0);
      @(negedge clk);
      a_target_ack = 1'b1;
      #1;
      check("a_ack_same_cycle", {31'd0, a_host_ack}, 32'd1);
      check("a_write_no_resp", {31'd0, a_host_resp}, 32'd0);
      @(negedge clk);
      a_host_req = 1'b0; a_host_we = 1'b0;
      #1;
      check("a_idle_req", {31'd0, a_target_req}, 32'd0);

      // always-pass read and response
      @(negedge clk);
      a_host_req = 1'b1; a_host_addr = 32'h2000_0000;
      #1;
      check("a_read_ack", {31'd0, a_host_ack}, 32'd1);
      @(negedge clk);
      a_host_req = 1'b0; a_target_ack = 1'b0;
      a_target_resp = 1'b1; a_target_rdata = 32'h1234_5678; exp_a.push_back(32'h1234_5678);
      @(negedge clk);
      a_target_resp = 1'b0; a_target_rdata = 32'd0;
      drain(0, "a_drain");

      // forced pass after MAX_STALL-1 closed cycles
      issue_b(1'b1, 32'hA5A5_0000, 32'h0BAD_F00D, at);
      check("b_forced_ack_cycle", at, 32'd3);
`ifdef SPLIT_DELAYER_STATS_EN
      check("b_req_stat", b_req_stat, 32'd3);
`endif

      // four reads, back-to-back responses, full-FIFO forced pop
      for (int i = 0; i < 4; i++) begin
         issue_b(1'b0, 32'h100 + 32'(i * 4), 32'd0, at);
         check("b_read_ack_cycle", at, 32'd3);
      end
      for (int i = 1; i <= 4; i++) begin
         b_target_resp = 1'b1; b_target_rdata = 32'(i); exp_b.push_back(32'(i));
         @(negedge clk);
      end
      b_target_resp = 1'b0; b_target_rdata = 32'd0;
      #1;
      check("b_full_pop", {31'd0, b_host_resp}, 32'd1);
      check("b_full_pop_data", b_host_rdata, 32'd1);
      drain(1, "b_drain_inorder");
      check("b_err_clean", {31'd0, b_err}, 32'd0);

      // credit: fifth read waits for one host_resp
      for (int i = 0; i < 4; i++) begin
         issue_b(1'b0, 32'h300 + 32'(i * 4), 32'd0, at);
         check("b_credit_fill_ack", at, 32'd3);
      end
      b_host_req = 1'b1; b_host_we = 1'b0; b_host_addr = 32'h400;
      acks = 0;
      for (int k = 0; k < 12; k++) begin
         #1;
         if (b_host_ack) acks++;
         @(negedge clk);
      end
      check("b_credit_block", acks, 32'd0);
      b_target_resp = 1'b1; b_target_rdata = 32'h55; exp_b.push_back(32'h55);
      rc = -1; ac = -1;
      for (int k = 0; k < 30; k++) begin
         #1;
         if (b_host_resp) rc = k;
         if (b_host_ack) begin
            ac = k;
            break;
         end
         @(negedge clk);
         b_target_resp = 1'b0; b_target_rdata = 32'd0;
      end
      check("b_credit_resp_cycle", rc, 32'd4);
      check("b_credit_ack_cycle", ac, 32'd5);
      @(negedge clk);
      b_host_req = 1'b0; b_host_addr = 32'd0;

      // reset with a queued response: it must never come back
      b_target_resp = 1'b1; b_target_rdata = 32'h77;
      @(negedge clk);
      b_target_resp = 1'b0; b_target_rdata = 32'd0;
      rst_n = 1'b0;
      #1;
      check("b_rst_resp", {31'd0, b_host_resp}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      check("b_no_replay", {31'd0, b_host_resp}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         issue_b(1'b0, 32'h500 + 32'(i * 4), 32'd0, at);
         check("b_credit_after_rst", at, 32'd3);
      end

      // overflow with pop held off: fifth push dropped, sticky error
      force dut_b.pop_s = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            #1;
            check("b_err_before_drop", {31'd0, b_err}, 32'd0);
         end
         b_target_resp = 1'b1; b_target_rdata = 32'h11 + 32'(i);
         if (i < 4) exp_b.push_back(32'h11 + 32'(i));
         @(negedge clk);
      end
      b_target_resp = 1'b0; b_target_rdata = 32'd0;
      #1;
      check("b_err_set", {31'd0, b_err}, 32'd1);
      release dut_b.pop_s;
      drain(1, "b_drain_after_overflow");
      check("b_err_held", {31'd0, b_err}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("b_err_reset", {31'd0, b_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
